// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and byte-level helpers for the iterative encryption core.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef logic [3:0] round_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constants, indexed by the 1-based round number.
    function automatic logic [7:0] rcon(input round_t rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_iter_enc_round.sv
// Combinational AES-128 forward round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey, plus one step of the on-the-fly key expansion.
module enc_round
    import aes_pkg::*;
(
    input  round_t         rc,
    input  logic [127:0]   state,
    input  logic [127:0]   round_key,
    input  logic           final_round,
    output logic [127:0]   state_next,
    output logic [127:0]   key_next
);

    logic [15:0][7:0] sb;
    logic [127:0]     sr;
    logic [127:0]     mc;
    logic [31:0]      w3_rot;
    logic [31:0]      w3_sub;
    logic [31:0]      w0n, w1n, w2n, w3n;

    // Byte gi sits at row gi%4, column gi/4; ShiftRows pulls from column (col+row)%4.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ((COL + ROW) % 4) * 4 + ROW;
            assign sb[gi] = sbox(state[127-8*gi -: 8]);
            assign sr[127-8*gi -: 8] = sb[SRC];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign mc[127-32*gi -: 32] = mix_col(sr[127-32*gi -: 32]);
        end
    endgenerate

    assign w3_rot = {round_key[23:0], round_key[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign w3_sub[31-8*gi -: 8] = sbox(w3_rot[31-8*gi -: 8]);
        end
    endgenerate

    assign w0n = round_key[127:96] ^ w3_sub ^ {rcon(rc), 24'h0};
    assign w1n = round_key[95:64]  ^ w0n;
    assign w2n = round_key[63:32]  ^ w1n;
    assign w3n = round_key[31:0]   ^ w2n;

    assign key_next   = {w0n, w1n, w2n, w3n};
    assign state_next = (final_round ? sr : mc) ^ key_next;

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core, one round per clock, valid/ready on both sides.
// Define AES_ENC_LAST_KEY_OUT_EN to expose the final round key on key_last.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] plaintext,
    input  logic [AES_BLK_W-1:0] key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] ct
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output logic [AES_BLK_W-1:0] key_last
`endif
);

    generate
        if (NR != AES_NR) begin : g_nr_check
            $error("aes_enc_iter: only NR=10 (AES-128) is supported");
        end
    endgenerate

    localparam round_t LAST_RC = round_t'(AES_NR);

    fsm_state_t           fsm_reg, fsm_next;
    logic [AES_BLK_W-1:0] state_reg;
    logic [AES_BLK_W-1:0] key_reg;
    round_t               rc;
    logic [AES_BLK_W-1:0] round_state;
    logic [AES_BLK_W-1:0] round_key;
    logic                 last_round;

    assign last_round = (rc == LAST_RC);

    enc_round u_enc_round (
        .rc          (rc),
        .state       (state_reg),
        .round_key   (key_reg),
        .final_round (last_round),
        .state_next  (round_state),
        .key_next    (round_key)
    );

    always_comb begin
        fsm_next  = fsm_reg;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_next = ROUND;
            end
            ROUND: begin
                if (last_round) fsm_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rc        <= '0;
            ct        <= '0;
        end else begin
            fsm_reg <= fsm_next;
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= plaintext ^ key;
                        key_reg   <= key;
                        rc        <= 4'd1;
                    end
                end
                ROUND: begin
                    state_reg <= round_state;
                    key_reg   <= round_key;
                    // rc parks at 10 through DONE so it never exceeds the round count.
                    if (last_round) ct <= round_state;
                    else            rc <= rc + 4'd1;
                end
                DONE: begin
                    if (out_ready) rc <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef AES_ENC_LAST_KEY_OUT_EN
    assign key_last = key_reg;
`endif

endmodule
